// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding, parity codes,
// default oversampling ratio and the bit-vote helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Receiver-side signal bundle: line, frame configuration
// and the per-frame result/status outputs.
interface uart_rx_sipo_if;

  logic       rx;
  logic       rx_en;
  logic       data_length;
  logic       stop_bits;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       frame_error;
  logic       start_error;

  modport master (
    output rx, rx_en, data_length,
    output stop_bits, parity_type,
    input  data_out, rx_done, rx_active,
    input  parity_error, frame_error,
    input  start_error
  );

  modport slave (
    input  rx, rx_en, data_length,
    input  stop_bits, parity_type,
    output data_out, rx_done, rx_active,
    output parity_error, frame_error,
    output start_error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge
// detector; o_valid rises once the flops carry real line samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall,
  output logic o_valid
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_warm <= 2'b00;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_warm <= {r_warm[0], 1'b1};
    end
  end

  assign o_rx_s  = r_sync;
  assign o_fall  = r_prev & ~r_sync;
  assign o_valid = r_warm[1];

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: 7/8 data bits, optional parity,
// one or two stop bits, 3-sample majority vote per bit.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       baud_clk,
  input  logic       arst_n,
  input  logic       rx,
  input  logic       rx_en,
  input  logic       data_length,
  input  logic       stop_bits,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       frame_error,
  output logic       start_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  // Start tick absorbs sync + edge-detect delay so votes sit mid-bit.
  localparam logic [TW-1:0] T_ENTRY = TW'(3);

  uart_rx_state_e r_state;
  uart_rx_state_e w_next;

  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [1:0]    r_smp;
  logic [7:0]    r_shift;
  logic          r_len8;
  logic          r_stop2;
  logic [1:0]    r_par;
  logic          r_pacc;
  logic          r_perr;
  logic          r_ferr;
  logic          r_armed;

  logic w_rx_s;
  logic w_fall;
  logic w_valid;
  logic w_start;
  logic w_vote;
  logic w_vote_tick;
  logic w_tick_last;
  logic w_bit_last;
  logic w_par_en;
  logic w_done;
  logic w_serr;
  logic w_enter;

  uart_rx_sync u_sync (
    .clk     (baud_clk),
    .rst_n   (arst_n),
    .i_rx    (rx),
    .o_rx_s  (w_rx_s),
    .o_fall  (w_fall),
    .o_valid (w_valid)
  );

  assign w_start     = r_armed & w_fall;
  assign w_vote      = maj3(r_smp[0], r_smp[1], w_rx_s);
  assign w_vote_tick = (r_tick == T_S2);
  assign w_tick_last = (r_tick == T_LAST);
  assign w_bit_last  = (r_bit == (r_len8 ? 3'd7 : 3'd6));
  assign w_par_en    = (r_par == PAR_ODD) | (r_par == PAR_EVEN);
  assign w_enter     = (r_state == IDLE) & (w_next == START);
  assign rx_active   = (r_state != IDLE);

  always_ff @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_serr = 1'b0;
    if (!rx_en) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:
          if (w_start) w_next = START;
        START:
          if (w_vote_tick && w_vote) begin
            w_next = IDLE;
            w_serr = 1'b1;
          end else if (w_tick_last) begin
            w_next = DATA;
          end
        DATA:
          if (w_tick_last && w_bit_last)
            w_next = w_par_en ? PARITY : STOP1;
        PARITY:
          if (w_tick_last) w_next = STOP1;
        STOP1:
          if (w_vote_tick && !r_stop2) begin
            w_next = IDLE;
            w_done = 1'b1;
          end else if (w_tick_last) begin
            w_next = STOP2;
          end
        STOP2:
          if (w_vote_tick) begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        default:
          w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tick       <= '0;
      r_bit        <= '0;
      r_smp        <= '0;
      r_shift      <= '0;
      r_len8       <= 1'b0;
      r_stop2      <= 1'b0;
      r_par        <= PAR_NONE;
      r_pacc       <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_armed      <= 1'b0;
      data_out     <= '0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      start_error  <= 1'b0;
    end else begin
      rx_done     <= w_done;
      start_error <= w_serr;

      if (w_next == IDLE)   r_tick <= '0;
      else if (w_enter)     r_tick <= T_ENTRY;
      else if (w_tick_last) r_tick <= '0;
      else                  r_tick <= r_tick + 1'b1;

      if (r_tick == T_S0) r_smp[0] <= w_rx_s;
      if (r_tick == T_S1) r_smp[1] <= w_rx_s;

      // Re-arm only on a genuine high line, so a held-low break
      // or a low line at reset release never looks like a start.
      if (w_enter)
        r_armed <= 1'b0;
      else if (r_state == IDLE && w_valid && w_rx_s)
        r_armed <= 1'b1;

      if (w_enter) begin
        r_len8  <= data_length;
        r_stop2 <= stop_bits;
        r_par   <= parity_type;
        r_bit   <= '0;
        r_pacc  <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end

      if (w_vote_tick) begin
        case (r_state)
          DATA: begin
            r_shift <= {w_vote, r_shift[7:1]};
            r_pacc  <= r_pacc ^ w_vote;
          end
          PARITY:
            r_perr <= (r_pacc ^ w_vote) != (r_par == PAR_ODD);
          STOP1:
            r_ferr <= ~w_vote;
          default: ;
        endcase
      end

      if (r_state == DATA && w_tick_last)
        r_bit <= r_bit + 3'd1;

      if (w_done) begin
        data_out     <= r_len8 ? r_shift
                               : {1'b0, r_shift[7:1]};
        parity_error <= r_perr;
        frame_error  <= r_ferr | ~w_vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Randomized scoreboard bench for uart_rx_sipo: frames are
// modelled from their bit lists, a monitor checks each result.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         t0;
    int         lat;
  } exp_t;

  logic       baud_clk = 1'b0;
  logic       arst_n   = 1'b0;
  int         cyc      = 0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  logic [7:0] last_data = 8'h00;
  exp_t       q_exp[$];
  int         q_serr[$];
  exp_t       mon_e;
  int         mon_t;
  int         mon_d;

  uart_rx_sipo_if bus ();

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_clk     (baud_clk),
    .arst_n       (arst_n),
    .rx           (bus.rx),
    .rx_en        (bus.rx_en),
    .data_length  (bus.data_length),
    .stop_bits    (bus.stop_bits),
    .parity_type  (bus.parity_type),
    .data_out     (bus.data_out),
    .rx_done      (bus.rx_done),
    .rx_active    (bus.rx_active),
    .parity_error (bus.parity_error),
    .frame_error  (bus.frame_error),
    .start_error  (bus.start_error)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc = cyc + 1;

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports.
  always @(negedge baud_clk) begin
    if (arst_n) begin
      if (bus.rx_done) begin
        if (q_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_done: unexpected pulse at cycle %0d", cyc);
        end else begin
          mon_e = q_exp.pop_front();
          chk8("data_out", bus.data_out, mon_e.data);
          chk1("parity_error", bus.parity_error, mon_e.perr);
          chk1("frame_error", bus.frame_error, mon_e.ferr);
          mon_d = cyc - mon_e.t0;
          n_cmp++;
          if (mon_d < mon_e.lat - 2 || mon_d > mon_e.lat + 2) begin
            n_bad++;
            $display("FAIL rx_done_latency: got %0d expected %0d+/-2",
                     mon_d, mon_e.lat);
          end
          last_data = mon_e.data;
        end
      end
      if (bus.start_error) begin
        if (q_serr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL start_error: unexpected pulse at cycle %0d", cyc);
        end else begin
          mon_t = q_serr.pop_front();
          mon_d = cyc - mon_t;
          n_cmp++;
          if (mon_d < OS / 2 - 1 || mon_d > OS / 2 + 3) begin
            n_bad++;
            $display("FAIL start_error_latency: got %0d expected %0d+/-2",
                     mon_d, OS / 2 + 1);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic len8,
                            input logic stop2, input logic [1:0] pt,
                            input logic pflip, input logic [1:0] sbad,
                            input bit brk);
    logic bits[$];
    logic [7:0] dm;
    logic par_on;
    logic pbit;
    exp_t e;
    dm     = len8 ? d : {1'b0, d[6:0]};
    par_on = (pt == PAR_ODD) || (pt == PAR_EVEN);
    pbit   = (^dm) ^ (pt == PAR_ODD) ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < (len8 ? 8 : 7); i++) bits.push_back(dm[i]);
    if (par_on) bits.push_back(pbit);
    bits.push_back(~sbad[0]);
    if (stop2) bits.push_back(~sbad[1]);
    e.data = dm;
    e.perr = par_on && (((^dm) ^ pbit) != (pt == PAR_ODD));
    e.ferr = sbad[0] | (stop2 & sbad[1]);
    e.lat  = (bits.size() - 1) * OS + OS / 2 + 1;
    e.t0   = cyc;
    bus.data_length = len8;
    bus.stop_bits   = stop2;
    bus.parity_type = pt;
    q_exp.push_back(e);
    for (int b = 0; b < bits.size(); b++) begin
      bus.rx = bits[b];
      if (b == 0) begin
        tick(OS / 2);
        bus.data_length = 1'($urandom);
        bus.stop_bits   = 1'($urandom);
        bus.parity_type = 2'($urandom);
        tick(OS / 2);
      end else begin
        tick(OS);
      end
    end
    if (brk) begin
      bus.rx = 1'b0;
      tick(3 * OS);
      chk1("break_no_restart", bus.rx_active, 1'b0);
      bus.rx = 1'b1;
      tick(2 * OS);
    end else if (bits[bits.size() - 1] == 1'b0) begin
      bus.rx = 1'b1;
      tick(2 * OS);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [1:0] rs;
    bus.rx          = 1'b1;
    bus.rx_en       = 1'b1;
    bus.data_length = 1'b1;
    bus.stop_bits   = 1'b0;
    bus.parity_type = PAR_NONE;

    repeat (3) @(posedge baud_clk);
    @(negedge baud_clk);
    chk8("reset_data_out", bus.data_out, 8'h00);
    chk1("reset_rx_done", bus.rx_done, 1'b0);
    chk1("reset_rx_active", bus.rx_active, 1'b0);
    chk1("reset_parity_error", bus.parity_error, 1'b0);
    chk1("reset_frame_error", bus.frame_error, 1'b0);
    chk1("reset_start_error", bus.start_error, 1'b0);
    @(posedge baud_clk);
    #1 arst_n = 1'b1;
    tick(4);

    send_frame(8'hA5, 1'b1, 1'b0, PAR_NONE, 1'b0, 2'b00, 1'b0);
    send_frame(8'h35, 1'b0, 1'b1, PAR_EVEN, 1'b0, 2'b00, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, PAR_NONE, 1'b0, 2'b00, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, PAR_NONE, 1'b0, 2'b00, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, PAR_ODD, 1'b0, 2'b01, 1'b1);

    q_serr.push_back(cyc);
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(2 * OS);
    chk8("glitch_data_hold", bus.data_out, last_data);
    chk1("glitch_frame_error_hold", bus.frame_error, 1'b1);

    send_frame(8'h35, 1'b0, 1'b1, PAR_EVEN, 1'b1, 2'b00, 1'b0);

    bus.data_length = 1'b1;
    bus.stop_bits   = 1'b0;
    bus.parity_type = PAR_NONE;
    bus.rx = 1'b0;
    tick(4 * OS + OS / 2);
    chk1("pre_reset_active", bus.rx_active, 1'b1);
    arst_n = 1'b0;
    tick(2);
    @(negedge baud_clk);
    chk8("midreset_data_out", bus.data_out, 8'h00);
    chk1("midreset_rx_active", bus.rx_active, 1'b0);
    chk1("midreset_parity_error", bus.parity_error, 1'b0);
    @(posedge baud_clk);
    #1 arst_n = 1'b1;
    last_data = 8'h00;
    tick(2 * OS);
    chk1("post_reset_low_line", bus.rx_active, 1'b0);
    bus.rx = 1'b1;
    tick(OS);
    send_frame(8'h5A, 1'b1, 1'b0, PAR_NONE, 1'b0, 2'b00, 1'b0);

    bus.rx = 1'b0;
    tick(OS);
    bus.rx = 1'b1;
    tick(2 * OS + OS / 2);
    bus.rx_en = 1'b0;
    tick(2);
    tick(OS);
    chk1("abort_rx_active", bus.rx_active, 1'b0);
    chk8("abort_data_hold", bus.data_out, last_data);
    bus.rx_en = 1'b1;
    tick(OS);

    bus.rx_en = 1'b0;
    bus.rx = 1'b0;
    tick(2 * OS);
    chk1("disabled_no_start", bus.rx_active, 1'b0);
    bus.rx = 1'b1;
    tick(OS);
    bus.rx_en = 1'b1;
    tick(OS);

    for (int n = 0; n < 25; n++) begin
      rd = 8'($urandom);
      rs = {1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 5) == 0)};
      send_frame(rd, 1'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) == 0), rs, 1'b0);
    end

    tick(4 * OS);
    chk8("pending_frames", 8'(q_exp.size()), 8'd0);
    chk8("pending_start_errors", 8'(q_serr.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving baud_clk cycles per bit; legal values are even and at least 8.
REQ-002 SHALL have port baud_clk, input, 1 bit: single clock, OVERSAMPLE times the bit rate; all state updates on its posedge.
REQ-003 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rx, input, 1 bit: serial line, asynchronous, idle high.
REQ-005 SHALL have port rx_en, input, 1 bit: receiver enable.
REQ-006 SHALL have port data_length, input, 1 bit: 1 selects 8 data bits, 0 selects 7.
REQ-007 SHALL have port stop_bits, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-008 SHALL have port parity_type, input, 2 bits: 00 none, 01 odd, 10 even, 11 none.
REQ-009 SHALL have port data_out, output, 8 bits: last received word.
REQ-010 SHALL have port rx_done, output, 1 bit: one-cycle frame-complete pulse.
REQ-011 SHALL have port rx_active, output, 1 bit: high from start-bit detection until return to IDLE.
REQ-012 SHALL have ports parity_error, frame_error and start_error, each output, 1 bit: per-frame status flags.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-015 In IDLE with rx_en=1, a synchronized 1->0 transition SHALL enter START; no transition is taken while rx_en=0.
REQ-016 SHALL latch data_length, stop_bits and parity_type on entry to START; changes mid-frame SHALL be ignored.
REQ-017 SHALL sample every bit by majority vote of three samples taken at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-018 If the START vote is 1, SHALL pulse start_error for one cycle and return to IDLE without asserting rx_done.
REQ-019 In DATA, SHALL shift bits LSB first, taking 8 or 7 bits; in 7-bit mode data_out[7] SHALL be 0.
REQ-020 SHALL enter PARITY only when parity_type is 01 or 10.
REQ-021 In PARITY, parity_error SHALL be set when XOR(data bits, parity bit) differs from 1 for odd or 0 for even.
REQ-022 SHALL set frame_error if any sampled stop bit is 0; STOP2 SHALL be entered only when the latched stop_bits=1.
REQ-023 After the final stop vote, on the next posedge SHALL pulse rx_done, update data_out, parity_error and frame_error, and enter IDLE; there is no wait for the remainder of the stop bit.
REQ-024 data_out and both error flags SHALL hold until the next rx_done.
REQ-025 After frame_error with rx still 0 (break), SHALL stay in IDLE until rx is seen high before re-arming.
REQ-026 Deasserting rx_en mid-frame SHALL abort to IDLE without rx_done and leave data_out unchanged.

Reset
REQ-027 While arst_n=0, SHALL set state IDLE, all counters 0, synchronizer flops 1, data_out 0, rx_done, rx_active and all error flags 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only at the next falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold state encodings, parity_type constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the OVERSAMPLE default, shared with the transmitter.
REQ-030 Sub-module uart_rx_sync SHALL hold the two-flop synchronizer and falling-edge detector.
REQ-031 Tick counter width SHALL be $clog2(OVERSAMPLE); bit counter width SHALL be 3.

Verification
REQ-032 8N1, frame 0xA5 -> rx_done once, data_out=0xA5, all errors 0, rx_done 10*16-7 cycles after the start edge (±2 for synchronizer).
REQ-033 7E2, data 0x35 with parity bit 0 -> data_out=0x35, parity_error=0; same frame with parity bit 1 -> parity_error=1.
REQ-034 8O1, 0x00 with stop bit forced 0 -> frame_error=1; rx held low afterwards -> no further start until rx returns high.
REQ-035 rx low pulse of 4 cycles in IDLE -> start_error pulse, no rx_done, data_out unchanged.
REQ-036 arst_n pulsed low during DATA bit 3, then a valid 0x5A frame -> only 0x5A reported, no spurious rx_done.
REQ-037 Back-to-back 8N1 frames 0x12 and 0x34 with no idle gap -> two rx_done pulses with the correct data.
